// File: rtl/link_pkg.sv
// Shared types and sizing for both ends of the serial byte link.
// Serializer and deserializer state enums use distinct prefixes so both can be imported together.
package link_pkg;

    localparam int WORD_W          = 8;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        SER_IDLE    = 2'd0,
        SER_SHIFT   = 2'd1,
        SER_WAIT_RX = 2'd2
    } ser_state_e;

    typedef enum logic [1:0] {
        DES_IDLE  = 2'd0,
        DES_RECV  = 2'd1,
        DES_HOLD  = 2'd2
    } des_state_e;

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry holding register between the upstream producer and the shifter.
// Accepts on wr_vld_i && wr_rdy_o; wr_rdy_o is registered and low while a word is held.
module ser_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clock_100KHz,
    input  logic             reset,
    input  logic             wr_vld_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    output logic             wr_rdy_o,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic             full_o
);

    logic             full_q, full_d;
    logic             rdy_q;
    logic [WIDTH-1:0] dat_q, dat_d;
    logic             accept;

    assign accept = wr_vld_i && rdy_q;

    // A read and a write on the same edge leave the register full with the new word.
    always_comb begin
        full_d = full_q;
        dat_d  = dat_q;
        if (rd_i) begin
            full_d = 1'b0;
        end
        if (accept) begin
            full_d = 1'b1;
            dat_d  = wr_dat_i;
        end
    end

    always_ff @(posedge clock_100KHz or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            rdy_q  <= 1'b1;
            dat_q  <= '0;
        end else begin
            full_q <= full_d;
            rdy_q  <= ~full_d;
            dat_q  <= dat_d;
        end
    end

    assign wr_rdy_o = rdy_q;
    assign rd_dat_o = dat_q;
    assign full_o   = full_q;

endmodule

// File: rtl/serializador.sv
// LSB-first parallel-to-serial transmitter; first bit on the wire two edges after acceptance.
// Upstream stalls via ready_out while a word is held; the receiver stalls us via status_in, with a sticky timeout.
module serializador
    import link_pkg::*;
#(
    parameter int WIDTH   = WORD_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clock_100KHz,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             write_out,
    input  logic             status_in,
    output logic             busy_out,
    output logic             error_out,
    output logic [7:0]       words_sent
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int TMO_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             data_q, data_d;
    logic             write_q, write_d;
    logic             busy_q;
    logic             err_q, err_d;
    logic [7:0]       words_q, words_d;

    logic             load;
    logic             hold_full;
    logic [WIDTH-1:0] hold_dat;

    ser_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clock_100KHz (clock_100KHz),
        .reset        (reset),
        .wr_vld_i     (data_valid_in),
        .wr_dat_i     (data_in),
        .wr_rdy_o     (ready_out),
        .rd_i         (load),
        .rd_dat_o     (hold_dat),
        .full_o       (hold_full)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tmo_d     = tmo_q;
        data_d    = 1'b0;
        write_d   = 1'b0;
        err_d     = err_q;
        words_d   = words_q;
        load      = 1'b0;

        case (state_q)
            SER_IDLE: begin
                // A low status_in means the receiver still holds the previous word.
                if (hold_full && status_in) begin
                    load      = 1'b1;
                    shift_d   = hold_dat;
                    bit_cnt_d = '0;
                    state_d   = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                data_d    = shift_q[0];
                write_d   = 1'b1;
                shift_d   = shift_q >> 1;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    tmo_d   = '0;
                    state_d = SER_WAIT_RX;
                end
            end
            SER_WAIT_RX: begin
                if (!status_in) begin
                    words_d = words_q + 8'd1;
                    state_d = SER_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_q == TMO_LAST) begin
                        err_d   = 1'b1;
                        state_d = SER_IDLE;
                    end
                end
            end
            default: begin
                state_d = SER_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_100KHz or posedge reset) begin
        if (reset) begin
            state_q   <= SER_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tmo_q     <= '0;
            data_q    <= 1'b0;
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            words_q   <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            write_q   <= write_d;
            busy_q    <= (state_d != SER_IDLE);
            err_q     <= err_d;
            words_q   <= words_d;
        end
    end

    assign data_out   = data_q;
    assign write_out  = write_q;
    assign busy_out   = busy_q;
    assign error_out  = err_q;
    assign words_sent = words_q;

endmodule

// File: tb/tb_serializador.sv
// Bench for serializador: timeline model of the expected wire activity plus directed scenarios.
module tb_serializador;

    localparam int TMO = 64;

    logic       clock_100KHz = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid_in = 1'b0;
    logic       status_in = 1'b1;
    logic       ready_out, data_out, write_out, busy_out, error_out;
    logic [7:0] words_sent;

    serializador #(.WIDTH(8), .TIMEOUT(TMO)) dut (
        .clock_100KHz  (clock_100KHz),
        .reset         (reset),
        .data_in       (data_in),
        .data_valid_in (data_valid_in),
        .ready_out     (ready_out),
        .data_out      (data_out),
        .write_out     (write_out),
        .status_in     (status_in),
        .busy_out      (busy_out),
        .error_out     (error_out),
        .words_sent    (words_sent)
    );

    always #5 clock_100KHz = ~clock_100KHz;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: once a word is loaded at edge L, bit k is on the wire after edge L+k+1,
    // and from edge L+9 onward the receiver's status decides ack or timeout.
    logic       m_hold_full = 1'b0, m_in_flight = 1'b0, m_ready = 1'b1;
    logic       m_wr = 1'b0, m_dat = 1'b0, m_busy = 1'b0, m_err = 1'b0;
    logic [7:0] m_hold = 8'h00, m_cur = 8'h00, m_words = 8'h00;
    logic       m_accept;
    int         m_n = 0, m_load_n = 0, m_k = 0;

    initial begin
        forever begin
            @(posedge clock_100KHz or posedge reset);
            if (reset) begin
                m_hold_full = 1'b0; m_in_flight = 1'b0; m_ready = 1'b1;
                m_wr = 1'b0; m_dat = 1'b0; m_busy = 1'b0; m_err = 1'b0;
                m_words = 8'h00;
            end else begin
                m_n++;
                m_accept = data_valid_in && m_ready;
                if (!m_in_flight) begin
                    if (m_hold_full && status_in) begin
                        m_cur = m_hold;
                        m_hold_full = 1'b0;
                        m_load_n = m_n;
                        m_in_flight = 1'b1;
                    end
                end else begin
                    m_k = m_n - m_load_n;
                    if (m_k >= 9) begin
                        if (!status_in) begin
                            m_words = m_words + 8'd1;
                            m_in_flight = 1'b0;
                        end else if (m_k - 9 == TMO - 1) begin
                            m_err = 1'b1;
                            m_in_flight = 1'b0;
                        end
                    end
                end
                if (m_accept) begin
                    m_hold = data_in;
                    m_hold_full = 1'b1;
                end
                m_ready = !m_hold_full;
                m_k = m_n - m_load_n;
                m_wr = m_in_flight && (m_k >= 1) && (m_k <= 8);
                m_dat = 1'b0;
                if (m_wr) m_dat = m_cur[m_k-1];
                m_busy = m_in_flight;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock_100KHz);
            check("ready_out",  {31'd0, ready_out}, {31'd0, m_ready});
            check("write_out",  {31'd0, write_out}, {31'd0, m_wr});
            check("data_out",   {31'd0, data_out},  {31'd0, m_dat});
            check("busy_out",   {31'd0, busy_out},  {31'd0, m_busy});
            check("error_out",  {31'd0, error_out}, {31'd0, m_err});
            check("words_sent", {24'd0, words_sent}, {24'd0, m_words});
        end
    end

    // Simple receiver for the bulk test: collects bits, then holds status low for one cycle.
    logic       auto_rx = 1'b0;
    logic [7:0] rx_sr = 8'h00;
    int         rx_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] sent_q[$];

    task automatic tick();
        @(posedge clock_100KHz);
        #2;
        if (auto_rx) begin
            if (!status_in) begin
                status_in = 1'b1;
            end else if (write_out) begin
                rx_sr[rx_cnt] = data_out;
                rx_cnt++;
                if (rx_cnt == 8) begin
                    rx_q.push_back(rx_sr);
                    rx_cnt = 0;
                    status_in = 1'b0;
                end
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic acc;
        int   g;
        g = 0;
        data_in = b;
        data_valid_in = 1'b1;
        do begin
            acc = ready_out;
            tick();
            g++;
        end while (!acc && g < 500);
        data_valid_in = 1'b0;
        check("send_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic wait_write(input logic val, input string name);
        int g;
        g = 0;
        while (write_out !== val && g < 300) begin
            tick();
            g++;
        end
        check(name, {31'd0, write_out}, {31'd0, val});
    endtask

    task automatic get_word(output logic [7:0] w, output int nwr);
        w = 8'h00;
        nwr = 0;
        wait_write(1'b1, "word_start");
        for (int k = 0; k < 8; k++) begin
            w[k] = data_out;
            nwr += int'(write_out);
            tick();
        end
    endtask

    task automatic ack_word();
        status_in = 1'b0;
        tick();
        status_in = 1'b1;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w, pat;
        int         nwr, cnt;

        repeat (3) @(posedge clock_100KHz);
        #2;
        check("rst_ready", {31'd0, ready_out}, 32'd1);
        check("rst_write", {31'd0, write_out}, 32'd0);
        reset = 1'b0;
        tick();

        // Receiver never acks: sticky error 64 WAIT_RX edges in, nothing counted.
        status_in = 1'b1;
        send(8'h42);
        wait_write(1'b1, "t1_burst");
        wait_write(1'b0, "t1_end");
        cnt = 0;
        while (error_out !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        check("t1_err_delay", cnt, 63);
        check("t1_words", {24'd0, words_sent}, 32'd0);
        check("t1_busy", {31'd0, busy_out}, 32'd0);
        repeat (5) tick();
        check("t1_err_sticky", {31'd0, error_out}, 32'd1);

        reset = 1'b1;
        tick();
        check("r1_err", {31'd0, error_out}, 32'd0);
        check("r1_ready", {31'd0, ready_out}, 32'd1);
        reset = 1'b0;
        tick();

        // 0xA5 bit by bit, then a one-cycle ack.
        send(8'hA5);
        get_word(w, nwr);
        pat = 8'hA5;
        for (int k = 0; k < 8; k++) check($sformatf("t2_bit%0d", k), {31'd0, w[k]}, {31'd0, pat[k]});
        check("t2_write_len", nwr, 8);
        check("t2_write_after", {31'd0, write_out}, 32'd0);
        ack_word();
        check("t2_words", {24'd0, words_sent}, 32'd1);
        check("t2_busy", {31'd0, busy_out}, 32'd0);

        // Back-to-back: 0x3C taken during the 0xA5 shift, sent only after the receiver cycles.
        send(8'hA5);
        send(8'h3C);
        check("t3_ready_held", {31'd0, ready_out}, 32'd0);
        wait_write(1'b0, "t3_first_end");
        status_in = 1'b0;
        repeat (3) tick();
        check("t3_stall_write", {31'd0, write_out}, 32'd0);
        check("t3_stall_ready", {31'd0, ready_out}, 32'd0);
        check("t3_words", {24'd0, words_sent}, 32'd2);
        status_in = 1'b1;
        get_word(w, nwr);
        check("t3_second", {24'd0, w}, 32'h3C);
        ack_word();
        check("t3_words2", {24'd0, words_sent}, 32'd3);

        // Pending word with the receiver busy: no pulses until status_in rises.
        status_in = 1'b0;
        send(8'h5A);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt += int'(write_out);
        end
        check("t4_no_write", cnt, 0);
        check("t4_ready", {31'd0, ready_out}, 32'd0);
        status_in = 1'b1;
        tick();
        check("t4_load_edge", {31'd0, write_out}, 32'd0);
        tick();
        check("t4_first_bit_wr", {31'd0, write_out}, 32'd1);
        check("t4_first_bit", {31'd0, data_out}, 32'd0);
        wait_write(1'b0, "t4_end");
        ack_word();
        check("t4_words", {24'd0, words_sent}, 32'd4);

        // Reset mid-word with a second word pending.
        send(8'hFF);
        send(8'h81);
        tick();
        tick();
        check("t5_mid_word", {31'd0, write_out}, 32'd1);
        reset = 1'b1;
        tick();
        check("t5_rst_data", {31'd0, data_out}, 32'd0);
        check("t5_rst_write", {31'd0, write_out}, 32'd0);
        check("t5_rst_ready", {31'd0, ready_out}, 32'd1);
        check("t5_rst_busy", {31'd0, busy_out}, 32'd0);
        check("t5_rst_words", {24'd0, words_sent}, 32'd0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cnt += int'(write_out);
        end
        check("t5_after_write", cnt, 0);
        check("t5_after_busy", {31'd0, busy_out}, 32'd0);

        // 256 words through the receiver model; counter wraps to zero.
        rx_cnt = 0;
        auto_rx = 1'b1;
        for (int i = 0; i < 256; i++) begin
            w = 8'(i * 7 + 3);
            sent_q.push_back(w);
            send(w);
        end
        cnt = 0;
        while (rx_q.size() < 256 && cnt < 5000) begin
            tick();
            cnt++;
        end
        repeat (4) tick();
        check("t6_rx_count", rx_q.size(), 256);
        for (int i = 0; i < 256 && i < rx_q.size(); i++)
            check($sformatf("t6_word%0d", i), {24'd0, rx_q[i]}, {24'd0, sent_q[i]});
        check("t6_words_wrap", {24'd0, words_sent}, 32'd0);
        check("t6_no_error", {31'd0, error_out}, 32'd0);
        auto_rx = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serializador.md
Name: serializador

Overview:
- Parallel-to-serial transmitter for the byte link: takes 8-bit words from an upstream producer and shifts them out LSB-first, one bit per clock, with a write strobe.
- Drives the far-end deserializer: data_out -> its data_in, write_out -> its write_in. Its status_out feeds status_in here.
- Holds one pending word while shifting, so upstream can hand over the next byte early.
- Detects a receiver that never completes the word handshake.

Parameters:
- WIDTH, 8, bits per word; bit_cnt is $clog2(WIDTH)+1 wide.
- TIMEOUT, 64, cycles allowed in WAIT_RX before error_out is raised.

Ports:
- clock_100KHz  input  1  system clock, all logic on its rising edge
- reset  input  1  asynchronous, active-high
- data_in  input  WIDTH  word from upstream
- data_valid_in  input  1  upstream offers data_in this cycle
- ready_out  output  1  holding register empty; word accepted on the edge where data_valid_in && ready_out
- data_out  output  1  serial bit to receiver
- write_out  output  1  data_out is valid this cycle
- status_in  input  1  receiver ready (high) / busy holding a word (low)
- busy_out  output  1  FSM not in IDLE
- error_out  output  1  sticky receiver-timeout flag
- words_sent  output  8  count of completed words, wraps 255->0

Behaviour:
- Interface as decided: reset reset, asynchronous, active-high; clock clock_100KHz. All outputs are registered.
- Reset values:
  - data_out=0, write_out=0, ready_out=1, busy_out=0, error_out=0, words_sent=0.
  - FSM=IDLE; hold_full=0; shift_reg, hold_reg, bit_cnt and tmo_cnt all 0.
- Reset mid-word aborts it: no partial bits after reset deasserts, and the held word is discarded.
- Upstream handshake:
  - On the edge with data_valid_in && ready_out: hold_reg<=data_in, hold_full<=1, ready_out<=0.
  - data_valid_in while ready_out=0 is ignored; the producer must keep it asserted.
- FSM states: IDLE, SHIFT, WAIT_RX.
- IDLE:
  - If hold_full && status_in: shift_reg<=hold_reg, hold_full<=0, ready_out<=1, bit_cnt<=0, go to SHIFT.
  - If status_in=0: stall, holding any word.
  - A word accepted upstream on that same edge goes into hold_reg. Load and accept on one edge is legal, and ready_out stays 0.
- SHIFT:
  - Each cycle: data_out<=shift_reg[0], write_out<=1, shift_reg>>=1, bit_cnt++.
  - Bit k of the word appears on data_out exactly k+1 cycles after the load edge.
  - After WIDTH bits (bit_cnt==WIDTH-1 at the edge): go to WAIT_RX, tmo_cnt<=0.
  - write_out is high for exactly WIDTH consecutive cycles per word.
  - status_in is not sampled during SHIFT.
- WAIT_RX:
  - write_out<=0, data_out<=0.
  - status_in==0 (receiver holding the word): words_sent++, go to IDLE.
  - Otherwise tmo_cnt++. At tmo_cnt==TIMEOUT-1: error_out<=1, words_sent unchanged, go to IDLE.
  - error_out clears only on reset.
  - IDLE then waits for status_in=1 (receiver acked) before the next word, so words are never overrun.
- Latency: best case, the first bit is on the wire 2 edges after acceptance (accept, then load). Word-to-word period is WIDTH + 1 + receiver turnaround.
- busy_out = (FSM != IDLE), registered with the state.

Decomposition:
- Shared package link_pkg: state enum for the serializer (IDLE, SHIFT, WAIT_RX) alongside the deserializer's state enum, plus WORD_W=8 and DEFAULT_TIMEOUT=64.
- One natural sub-module, ser_hold_reg: the one-entry holding register with valid/ready handshake.
- Shift FSM and counters stay in the top module.

Test Plan:
- Send 0xA5 with status_in=1 -> write_out high for 8 cycles, data_out 1,0,1,0,0,1,0,1. Pull status_in low 1 cycle later -> words_sent=1, busy_out falls.
- Offer 0xA5 then 0x3C back-to-back -> 0x3C accepted during the shift of 0xA5, ready_out=0 until 0x3C loads. 0x3C is shifted only after status_in goes 0 then 1, giving bits 0,0,1,1,1,1,0,0.
- Hold status_in=0 with a word pending -> no write_out pulses, ready_out=0. Raise status_in -> shifting starts next edge.
- Keep status_in=1 forever after a word (TIMEOUT=64) -> error_out rises 64 cycles into WAIT_RX, words_sent stays 0, FSM returns to IDLE.
- Assert reset after 3 bits of 0xFF with 0x81 pending -> all outputs at reset values. After release, no further write_out until a new word arrives.
- Send 256 words through a deserializer model -> received data matches, words_sent wraps to 0.
